// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide opcodes and the MDU sequencer state encoding.
package cpu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit and the multiply-divide unit.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  op;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;

  modport master (
    output start, op, signed_op, a, b,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, signed_op, a, b,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/nr_div_step.sv
// One combinational shift-subtract division iteration on unsigned magnitudes.
module nr_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH+1:0] diff;

  always_comb begin
    // Partial remainder shifted left with the next dividend bit; the top bit of diff is the borrow.
    diff = {rem_i, quo_i[DATA_WIDTH-1]} - {2'b00, dvs_i};
    if (diff[DATA_WIDTH+1]) begin
      rem_o = {rem_i[DATA_WIDTH-1:0], quo_i[DATA_WIDTH-1]};
    end else begin
      rem_o = diff[DATA_WIDTH:0];
    end
    quo_o = {quo_i[DATA_WIDTH-2:0], ~diff[DATA_WIDTH+1]};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit feeding the HI/LO registers.
// Works on operand magnitudes for W iterations, then applies the result signs in one fix-up cycle.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clock,
  input  logic           clear_n,
  mul_div_unit_if.slave  bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
  endfunction

  mdu_state_t       state_q, state_d;
  logic             op_q, op_d;
  logic             neg_q, neg_d;
  logic             rsign_q, rsign_d;
  logic [W-1:0]     ma_q, ma_d;
  logic [W-1:0]     mb_q, mb_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [W:0]       mul_sum;
  logic [W:0]       step_rem;
  logic [W-1:0]     step_quo;

  nr_div_step #(.DATA_WIDTH(W)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (mb_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rsign_d = rsign_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    // Radix-2 shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, ma_q} : {(W+1){1'b0}});

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          ma_d    = mag(bus.a, bus.signed_op);
          mb_d    = mag(bus.b, bus.signed_op);
          neg_d   = bus.signed_op & (bus.a[W-1] ^ bus.b[W-1]);
          rsign_d = bus.signed_op & bus.a[W-1];
          cnt_d   = '0;
          acc_d   = {{W{1'b0}}, mb_d};
          rem_d   = '0;
          quo_d   = ma_d;
          dz_d    = 1'b0;
          if (bus.op == OP_DIV && bus.b == '0) begin
            dz_d    = 1'b1;
            hi_d    = bus.a;
            lo_d    = '1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
        end
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        if (op_q == OP_MUL) begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end else begin
          lo_d = neg_q ? -quo_q : quo_q;
          hi_d = W'(rsign_q ? -rem_q : rem_q);
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Working registers are only meaningful between an accepted start and DONE, so they need no reset.
  always_ff @(posedge clock) begin
    op_q    <= op_d;
    neg_q   <= neg_d;
    rsign_q <= rsign_d;
    ma_q    <= ma_d;
    mb_q    <= mb_d;
    acc_q   <= acc_d;
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    cnt_q   <= cnt_d;
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at DATA_WIDTH=32.
module tb_mul_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk;
  logic clear_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  mul_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clock   (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: native 64-bit products and truncating integer division.
  function automatic exp_t model(input logic op, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sbv;
    e.dz  = 1'b0;
    e.lat = W + 1;
    if (op == 1'b0) begin
      if (sgn) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {e.hi, e.lo} = sp;
      end else begin
        up = {32'h0, a} * {32'h0, b};
        {e.hi, e.lo} = up;
      end
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dz  = 1'b1;
      e.lat = 0;
    end else if (sgn) begin
      sa  = $signed(a);
      sbv = $signed(b);
      if (sa == int'(32'h8000_0000) && sbv == -1) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        e.lo = sa / sbv;
        e.hi = sa % sbv;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Called at #1 after an edge with the DUT idle; leaves the DUT idle again at #1 after an edge.
  task automatic run_op(input logic op, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit pulse_mid);
    exp_t e;
    int   edges;
    sb_q.push_back(model(op, sgn, a, b));
    bus.start     = 1'b1;
    bus.op        = op;
    bus.signed_op = sgn;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges     = 0;
    chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    chk("dz_after_accept", {63'd0, bus.div_by_zero}, {63'd0, sb_q[0].dz});
    while (!bus.done && edges < 200) begin
      if (pulse_mid && edges == 5) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = b + 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    bus.start = 1'b0;
    if (!bus.done) chk("timeout_done", {63'd0, bus.done}, 64'd1);
    e = sb_q.pop_front();
    chk("latency", 64'(edges), 64'(e.lat));
    chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
    chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
    chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dz});
    chk("busy_in_done", {63'd0, bus.busy}, 64'd1);
    @(posedge clk);
    #1;
    chk("done_pulse_end", {63'd0, bus.done}, 64'd0);
    chk("busy_end", {63'd0, bus.busy}, 64'd0);
    chk("hi_hold", {32'd0, bus.hi}, {32'd0, e.hi});
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;
    logic         rsg;
    n_checks      = 0;
    n_fail        = 0;
    clear_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_dz", {63'd0, bus.div_by_zero}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFC, 1'b0);
    run_op(1'b0, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    for (int i = 0; i < 16; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      if (i % 4 == 3) rb = rb >> 20;
      run_op(rop, rsg, ra, rb, (i % 5 == 2));
    end

    // Abort: start a divide, re-request mid-flight, then pull reset before it finishes.
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 1'b0);
    bus.start     = 1'b1;
    bus.op        = 1'b1;
    bus.signed_op = 1'b0;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    chk("abort_no_done", {63'd0, bus.done}, 64'd0);
    repeat (4) @(posedge clk);
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);

    if (sb_q.size() != 0) chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
